alu_seq: RTL

- Parametrised, handshaked successor to the team's single-cycle ALU.
- Computes WIDTH-bit arithmetic, logic and shift operations with 1-cycle latency, plus an iterative unsigned multiply taking WIDTH+1 cycles.
- Registered result and a flag vector are presented through a valid/ready output stage with backpressure.
- Sits between an operand-issuing controller and a result consumer. The interface-bundle bench drives it.

---
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle arithmetic/logic/shift operations
// and an iterative shift-add unsigned multiply. The result, high product half
// and flags {E,V,C,N,Z} sit in output registers behind a valid/ready stage.
module alu_seq #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_hi,
  output logic [4:0]       flags
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t state_q, state_d;

  logic                 accept;
  logic                 mul_last;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH:0]       step_sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [4:0]           mul_flags;

  logic [SHW-1:0]       sh;
  logic [WIDTH:0]       add_ext;
  logic [WIDTH:0]       sub_ext;
  logic [WIDTH:0]       shl_ext;
  logic [WIDTH:0]       shr_ext;
  logic signed [WIDTH:0] sra_ext;

  logic [WIDTH-1:0]     res;
  logic [WIDTH-1:0]     res_c;
  logic                 c_flag, v_flag, e_flag, z_flag, n_flag;
  logic [4:0]           res_flags;

  // The extra bit on each shift extension catches the last bit shifted out
  assign sh      = b[SHW-1:0];
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};
  assign shl_ext = {1'b0, a} << sh;
  assign shr_ext = {a, 1'b0} >> sh;
  assign sra_ext = $signed({a, 1'b0}) >>> sh;

  assign accept   = in_valid && in_ready;
  assign mul_last = (state_q == S_MUL) && (cnt_q == CW'(WIDTH));

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole accumulator right
  assign step_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_step  = {step_sum, acc_q[WIDTH-1:1]};
  assign mul_flags = {1'b0, 1'b0, (acc_q[2*WIDTH-1:WIDTH] != '0), acc_q[2*WIDTH-1], (acc_q == '0)};

  // Single-cycle result and flags; CMP keeps the subtract flags but returns zero
  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    e_flag = 1'b0;
    case (opcode)
      OP_ADD: begin
        res    = add_ext[MSB:0];
        c_flag = add_ext[WIDTH];
        v_flag = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res    = sub_ext[MSB:0];
        c_flag = sub_ext[WIDTH];
        v_flag = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL: begin
        res    = shl_ext[MSB:0];
        c_flag = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res    = shr_ext[WIDTH:1];
        c_flag = shr_ext[0];
      end
      OP_SRA: begin
        res    = sra_ext[WIDTH:1];
        c_flag = sra_ext[0];
      end
      OP_MUL:  res = '0;
      OP_PASS: res = a;
      default: e_flag = 1'b1;
    endcase
    z_flag = (res == '0) && !e_flag;
    n_flag = res[MSB];
    res_c  = (opcode == OP_CMP) ? '0 : res;
    res_flags = {e_flag, v_flag, c_flag, n_flag, z_flag};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a multiply holds the block busy until its result is written
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && opcode == OP_MUL) state_d = S_MUL;
      S_MUL:   if (mul_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accept only when idle and the output register is free or draining now
  always_comb begin
    in_ready = !reset && (state_q == S_IDLE) && (!out_valid || out_ready);
  end

  // Output registers and multiplier datapath; a new result overrides a drain
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      c         <= '0;
      c_hi      <= '0;
      flags     <= '0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (opcode == OP_MUL) begin
          mcand_q <= a;
          acc_q   <= {{WIDTH{1'b0}}, b};
          cnt_q   <= '0;
        end else begin
          c         <= res_c;
          c_hi      <= '0;
          flags     <= res_flags;
          out_valid <= 1'b1;
        end
      end else if (state_q == S_MUL) begin
        if (mul_last) begin
          {c_hi, c} <= acc_q;
          flags     <= mul_flags;
          out_valid <= 1'b1;
          cnt_q     <= '0;
        end else begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule
